// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, opcodes and the fetch-stage state type.
package cpu_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_JAL = 7'b1101111;

    typedef enum logic [1:0] {
        FETCH     = 2'd0,
        MISS_WAIT = 2'd1,
        DROP      = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/jal_predict.sv
// Static next-PC predictor: JAL is assumed taken, everything else falls through to pc+4.
module jal_predict
    import cpu_pkg::*;
(
    input  logic [XLEN-1:0] inst,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pred_pc
);

    logic            is_jal;
    logic [XLEN-1:0] jal_offset;
    logic            unused_rd;

    assign is_jal     = (inst[6:0] == OPC_JAL);
    assign jal_offset = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign unused_rd  = ^inst[11:7];

    // 32-bit wrap-around is intentional; targets may cross 0 in either direction.
    assign pred_pc = is_jal ? (pc + jal_offset) : (pc + 32'd4);

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: PC register, same-cycle I-cache lookup, single outstanding miss to memory,
// and redirect handling that lets an in-flight miss drain into the cache.
//
// Handshakes: iq_push is a strobe that only fires when iq_full is low; mem_req_valid is a
// level held with a stable address until the one-cycle mem_resp_valid; rdy low freezes all.
module inst_fetch
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rdy,
    output logic [XLEN-1:0] ic_addr,
    input  logic            ic_hit,
    input  logic [XLEN-1:0] ic_inst,
    output logic            ic_fill_en,
    output logic [XLEN-1:0] ic_fill_addr,
    output logic [XLEN-1:0] ic_fill_inst,
    output logic            mem_req_valid,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_resp_inst,
    input  logic            iq_full,
    output logic            iq_push,
    output logic [XLEN-1:0] iq_inst,
    output logic [XLEN-1:0] iq_pc,
    output logic [XLEN-1:0] iq_pred_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output fetch_state_t    dbg_state
);

    fetch_state_t    state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic [XLEN-1:0] miss_pc, miss_pc_nxt;
    logic [XLEN-1:0] pred_pc;
    logic [XLEN-1:0] redirect_target;
    logic            push;
    logic            fill;

    assign redirect_target = redirect_pc & ~32'h3;

    jal_predict u_jal_predict (
        .inst    (ic_inst),
        .pc      (pc),
        .pred_pc (pred_pc)
    );

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        miss_pc_nxt = miss_pc;
        push        = 1'b0;
        fill        = 1'b0;
        if (rdy && rst_n) begin
            case (state)
                FETCH: begin
                    if (redirect_valid) begin
                        pc_nxt = redirect_target;
                    end else if (ic_hit) begin
                        if (!iq_full) begin
                            push   = 1'b1;
                            pc_nxt = pred_pc;
                        end
                    end else begin
                        miss_pc_nxt = pc;
                        state_nxt   = MISS_WAIT;
                    end
                end
                MISS_WAIT, DROP: begin
                    // The response is always written back: it is valid data for miss_pc
                    // even when the fetch stream has already moved on.
                    if (mem_resp_valid) begin
                        fill      = 1'b1;
                        state_nxt = FETCH;
                    end else if (redirect_valid) begin
                        state_nxt = DROP;
                    end
                    if (redirect_valid) begin
                        pc_nxt = redirect_target;
                    end
                end
                default: state_nxt = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            miss_pc <= '0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            miss_pc <= miss_pc_nxt;
        end
    end

    assign ic_addr       = pc;
    assign iq_push       = push;
    assign iq_inst       = ic_inst;
    assign iq_pc         = pc;
    assign iq_pred_pc    = pred_pc;
    assign ic_fill_en    = fill;
    assign ic_fill_addr  = miss_pc;
    assign ic_fill_inst  = mem_resp_inst;
    assign mem_req_valid = rst_n && (state != FETCH);
    assign mem_req_addr  = miss_pc;
    assign dbg_state     = state;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: I-cache and memory models, directed scenarios, random traffic,
// and a monitor that scores every push against a program-flow reference model.
module tb_inst_fetch;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rdy = 1'b0;
    logic        ic_hit = 1'b0;
    logic [31:0] ic_inst = 32'h0;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_inst = 32'h0;
    logic        iq_full = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    logic [31:0] ic_addr, ic_fill_addr, ic_fill_inst, mem_req_addr;
    logic [31:0] iq_inst, iq_pc, iq_pred_pc;
    logic        ic_fill_en, mem_req_valid, iq_push;
    fetch_state_t dbg_state;

    always #5 clk = ~clk;

    inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rdy            (rdy),
        .ic_addr        (ic_addr),
        .ic_hit         (ic_hit),
        .ic_inst        (ic_inst),
        .ic_fill_en     (ic_fill_en),
        .ic_fill_addr   (ic_fill_addr),
        .ic_fill_inst   (ic_fill_inst),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_inst  (mem_resp_inst),
        .iq_full        (iq_full),
        .iq_push        (iq_push),
        .iq_inst        (iq_inst),
        .iq_pc          (iq_pc),
        .iq_pred_pc     (iq_pred_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dbg_state      (dbg_state)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pred;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] cache [logic [31:0]];
    logic [31:0] prog_ovr [logic [31:0]];
    int          n_checks = 0;
    int          n_fail = 0;
    int          push_cnt = 0;
    int          mem_lat = 3;
    int          mem_cnt = 0;

    // ---------------- reference model ----------------
    function automatic logic [31:0] enc_jal(input int off);
        logic [20:0] im;
        im = off[20:0];
        return {im[20], im[10:1], im[11], im[19:12], 5'd1, 7'h6F};
    endfunction

    // Backing program: fixed hash of the address, with occasional short JALs.
    function automatic logic [31:0] prog(input logic [31:0] a);
        logic [31:0] h;
        if (prog_ovr.exists(a)) return prog_ovr[a];
        h = (a ^ 32'h5bd1_e995) * 32'h27d4_eb2d;
        h = h ^ (h >> 15);
        if (h[2:0] == 3'd0) return enc_jal(int'(h[10:4]) * 4 - 256);
        return {h[31:7], 7'h13};
    endfunction

    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] inst);
        int off;
        if (inst[6:0] == 7'b1101111) begin
            off = int'(inst[30:21]) * 2 + int'(inst[20]) * 2048 + int'(inst[19:12]) * 4096
                  - (inst[31] ? 1048576 : 0);
            return pc + 32'(off);
        end
        return pc + 32'd4;
    endfunction

    function automatic exp_t mk(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.inst = prog(pc);
        e.pred = ref_next(pc, e.inst);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- I-cache lookup and memory controller model ----------------
    always @(posedge clk or negedge rst_n) begin
        #1;
        if (!rst_n) begin
            mem_cnt        = 0;
            mem_resp_valid = 1'b0;
        end else if (mem_resp_valid) begin
            if (rdy) begin
                mem_resp_valid = 1'b0;
                mem_cnt        = 0;
            end
        end else if (mem_req_valid === 1'b1 && rdy) begin
            mem_cnt++;
            if (mem_cnt >= mem_lat) begin
                mem_resp_valid = 1'b1;
                mem_resp_inst  = prog(mem_req_addr);
            end
        end
        ic_hit  = cache.exists(ic_addr);
        ic_inst = ic_hit ? cache[ic_addr] : 32'hDEAD_BEEF;
    end

    // ---------------- monitor / scoreboard ----------------
    logic [31:0] prev_addr = 32'h0;
    logic        prev_hit = 1'b0;
    logic        req_seen = 1'b0;
    logic [31:0] req_addr = 32'h0;

    always @(negedge clk) begin
        exp_t e;
        #1;
        if (!rst_n) begin
            req_seen = 1'b0;
        end else begin
            check("pc_aligned", {30'b0, ic_addr[1:0]}, 32'h0);
            if (!rdy) check("frozen_strobes", {30'b0, iq_push, ic_fill_en}, 32'h0);
            if (iq_push) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL push_unexpected: got push at pc %h expected none", iq_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("push_pc", iq_pc, e.pc);
                    check("push_inst", iq_inst, e.inst);
                    check("push_pred", iq_pred_pc, e.pred);
                    exp_q.push_back(mk(e.pred));
                end
                push_cnt++;
            end
            if (mem_req_valid) begin
                if (!req_seen) begin
                    check("req_addr_is_miss_pc", mem_req_addr, prev_addr);
                    check("req_only_on_miss", {31'b0, prev_hit}, 32'h0);
                end else begin
                    check("req_addr_stable", mem_req_addr, req_addr);
                end
                req_seen = 1'b1;
                req_addr = mem_req_addr;
            end else begin
                req_seen = 1'b0;
            end
            if (ic_fill_en) begin
                check("fill_needs_resp", {31'b0, mem_resp_valid}, 32'h1);
                check("fill_addr", ic_fill_addr, req_addr);
                check("fill_data", ic_fill_inst, prog(req_addr));
                cache[ic_fill_addr] = ic_fill_inst;
            end
            prev_addr = ic_addr;
            prev_hit  = ic_hit;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic reset_model(input int lat);
        rdy            = 1'b1;
        iq_full        = 1'b0;
        redirect_valid = 1'b0;
        mem_lat        = lat;
        exp_q.delete();
        exp_q.push_back(mk(32'h0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, 32'(dbg_state), 32'(FETCH));
        check({tag, "_ic_addr"}, ic_addr, 32'h0);
        check({tag, "_push"}, {31'b0, iq_push}, 32'h0);
        check({tag, "_fill_en"}, {31'b0, ic_fill_en}, 32'h0);
        check({tag, "_req_valid"}, {31'b0, mem_req_valid}, 32'h0);
        check({tag, "_req_addr"}, mem_req_addr, 32'h0);
    endtask

    task automatic do_reset(input int lat);
        tick();
        rst_n = 1'b0;
        reset_model(lat);
        settle();
        check_reset_outputs("reset");
        tick();
        rst_n = 1'b1;
    endtask

    task automatic drive_redirect(input logic [31:0] a);
        redirect_valid = 1'b1;
        redirect_pc    = a;
        if (rdy) begin
            exp_q.delete();
            exp_q.push_back(mk(a & ~32'h3));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached with %0d checks", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        int   p0;

        // Three cached words from reset: back-to-back pushes.
        prog_ovr[32'h0] = 32'h0010_0093;
        prog_ovr[32'h4] = 32'h0020_0113;
        prog_ovr[32'h8] = 32'h0030_0193;
        cache.delete();
        for (int i = 0; i < 3; i++) cache[32'(i * 4)] = prog(32'(i * 4));
        do_reset(3);
        for (int i = 0; i < 3; i++) begin
            settle();
            check("t1_push", {31'b0, iq_push}, 32'h1);
            check("t1_pc", iq_pc, 32'(i * 4));
            check("t1_pred", iq_pred_pc, 32'(i * 4 + 4));
            tick();
        end

        // Cold miss, latency 3: three request cycles, fill on the last, push next.
        cache.delete();
        do_reset(3);
        settle();
        check("t2_no_req_first", {31'b0, mem_req_valid}, 32'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            settle();
            check("t2_req", {31'b0, mem_req_valid}, 32'h1);
            check("t2_req_addr", mem_req_addr, 32'h0);
            check("t2_fill_en", {31'b0, ic_fill_en}, (i == 2) ? 32'h1 : 32'h0);
            tick();
        end
        settle();
        check("t2_push_after_fill", {31'b0, iq_push}, 32'h1);
        check("t2_push_pc", iq_pc, 32'h0);

        // JAL forward (+16 at 0x10) and backward (-8 at 0x0, wrapping).
        prog_ovr[32'h10] = 32'h0100_006F;
        cache.delete();
        cache[32'h10] = prog(32'h10);
        do_reset(2);
        drive_redirect(32'h10);
        tick();
        redirect_valid = 1'b0;
        settle();
        check("t3_jal_push", {31'b0, iq_push}, 32'h1);
        check("t3_jal_pc", iq_pc, 32'h10);
        check("t3_jal_pred", iq_pred_pc, 32'h20);
        tick();
        settle();
        check("t3_jal_next", ic_addr, 32'h20);

        prog_ovr[32'h0] = 32'hFF9F_F06F;
        cache.delete();
        cache[32'h0] = prog(32'h0);
        do_reset(2);
        settle();
        check("t3_jal_neg_pred", iq_pred_pc, 32'hFFFF_FFF8);
        tick();
        settle();
        check("t3_jal_neg_next", ic_addr, 32'hFFFF_FFF8);

        // Redirect two cycles into a miss: drain into the cache, then restart at 0x100.
        cache.delete();
        cache[32'h100] = prog(32'h100);
        do_reset(5);
        tick();
        tick();
        drive_redirect(32'h103);
        tick();
        redirect_valid = 1'b0;
        settle();
        check("t4_state_drop", 32'(dbg_state), 32'(DROP));
        check("t4_pc_redirected", ic_addr, 32'h100);
        check("t4_req_addr_old", mem_req_addr, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (ic_fill_en) begin
                found = 1'b1;
            end else begin
                check("t4_req_held", {31'b0, mem_req_valid}, 32'h1);
                check("t4_no_push", {31'b0, iq_push}, 32'h0);
                tick();
                settle();
            end
        end
        check("t4_fill_seen", {31'b0, found}, 32'h1);
        check("t4_fill_old_addr", ic_fill_addr, 32'h0);
        tick();
        settle();
        check("t4_state_fetch", 32'(dbg_state), 32'(FETCH));
        check("t4_push_new", {31'b0, iq_push}, 32'h1);
        check("t4_push_new_pc", iq_pc, 32'h100);

        // Back-pressure for 4 cycles on a hitting stream.
        cache.delete();
        for (int i = 0; i < 16; i++) begin
            prog_ovr[32'(i * 4)] = 32'h0000_0013;
            cache[32'(i * 4)]    = 32'h0000_0013;
        end
        do_reset(2);
        tick();
        tick();
        iq_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("t5_no_push", {31'b0, iq_push}, 32'h0);
            check("t5_pc_frozen", ic_addr, 32'h8);
            tick();
        end
        iq_full = 1'b0;
        settle();
        check("t5_resume_push", {31'b0, iq_push}, 32'h1);
        check("t5_resume_pc", iq_pc, 32'h8);

        // rdy low mid-miss, then an asynchronous reset pulse mid-miss.
        cache.delete();
        do_reset(3);
        drive_redirect(32'h40);
        tick();
        redirect_valid = 1'b0;
        tick();
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            check("t6_state_frozen", 32'(dbg_state), 32'(MISS_WAIT));
            check("t6_req_held", {31'b0, mem_req_valid}, 32'h1);
            check("t6_req_addr", mem_req_addr, 32'h40);
            check("t6_no_fill", {31'b0, ic_fill_en}, 32'h0);
            tick();
        end
        rdy = 1'b1;
        settle();
        check("t6_still_miss", 32'(dbg_state), 32'(MISS_WAIT));
        #1;
        rst_n = 1'b0;
        reset_model(3);
        #1;
        check_reset_outputs("t6_async");
        tick();
        rst_n = 1'b1;

        // Random traffic: rdy, back-pressure, redirects, varying memory latency.
        for (int r = 0; r < 2; r++) begin
            cache.delete();
            prog_ovr.delete();
            do_reset(int'($urandom_range(1, 4)));
            p0 = push_cnt;
            for (int c = 0; c < 1500; c++) begin
                rdy            = ($urandom_range(0, 9) != 0);
                iq_full        = ($urandom_range(0, 3) == 0);
                redirect_valid = 1'b0;
                if ($urandom_range(0, 24) == 0)
                    drive_redirect({(($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'h0000),
                                    16'($urandom_range(0, 1023))});
                tick();
            end
            rdy            = 1'b1;
            iq_full        = 1'b0;
            redirect_valid = 1'b0;
            check("rand_progress", {31'b0, (push_cnt > p0 + 50)}, 32'h1);
        end

        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
